// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit: sign/zero/load-upper/branch-offset extension
// behind a valid/ready input, one output register and a one-entry skid buffer.
module imm_ext_pipe #(
    parameter int WORD_LENGTH = 32,
    parameter int IMM_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IMM_WIDTH-1:0]   Data,
    input  logic [1:0]             ExtMode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] ExtImm
);

    localparam int PAD_W = WORD_LENGTH - IMM_WIDTH;

    // Handshake: a word moves on a port in any cycle where valid and ready are
    // both high at the rising edge; valid never drops and data never changes
    // while the other side holds ready low.

    // State bits are {out_valid, skid_valid}; (0,1) is never produced.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [WORD_LENGTH-1:0] r_out;
    logic [WORD_LENGTH-1:0] r_skid;

    logic [WORD_LENGTH-1:0] w_sext;
    logic [WORD_LENGTH-1:0] w_zext;
    logic [WORD_LENGTH-1:0] w_lui;
    logic [WORD_LENGTH-1:0] w_br;
    logic [WORD_LENGTH-1:0] w_ext;
    logic                   w_accept;
    logic                   w_slot_free;
    logic                   w_load_out_from_in;
    logic                   w_load_out_from_skid;
    logic                   w_load_skid;

    assign w_sext = {{PAD_W{Data[IMM_WIDTH-1]}}, Data};
    assign w_zext = {{PAD_W{1'b0}}, Data};
    assign w_lui  = {Data, {PAD_W{1'b0}}};
    assign w_br   = {w_sext[WORD_LENGTH-3:0], 2'b00};

    always_comb begin
        w_ext = w_sext;
        case (ExtMode)
            2'b01:   w_ext = w_zext;
            2'b10:   w_ext = w_lui;
            2'b11:   w_ext = w_br;
            default: w_ext = w_sext;
        endcase
    end

    // in_ready comes straight from the skid flag so out_ready never reaches it.
    assign in_ready    = ~r_state[0];
    assign out_valid   = r_state[1];
    assign ExtImm      = r_out;
    assign w_accept    = in_valid & in_ready;
    assign w_slot_free = ~r_state[1] | out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state         = r_state;
        w_load_out_from_in   = 1'b0;
        w_load_out_from_skid = 1'b0;
        w_load_skid          = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_out_from_in = 1'b1;
                    w_next_state       = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_slot_free) begin
                    w_load_out_from_in = w_accept;
                    w_next_state       = w_accept ? ST_ONE : ST_EMPTY;
                end else if (w_accept) begin
                    w_load_skid  = 1'b1;
                    w_next_state = ST_FULL;
                end
            end
            ST_FULL: begin
                // Skid drains first, keeping strict FIFO order.
                if (w_slot_free) begin
                    w_load_out_from_skid = 1'b1;
                    w_next_state         = ST_ONE;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_out_from_skid) begin
                r_out <= r_skid;
            end else if (w_load_out_from_in) begin
                r_out <= w_ext;
            end
            if (w_load_skid) begin
                r_skid <= w_ext;
            end
        end
    end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate-extension unit for the MIPS datapath. It turns an IMM_WIDTH-bit instruction immediate into a WORD_LENGTH-bit operand in one of four modes: sign-extend, zero-extend, load-upper and branch-offset. Input and output use valid/ready handshakes, and a one-entry skid buffer provides full throughput under backpressure. It sits between instruction decode and the execute-stage operand mux.

## Interface
- WORD_LENGTH, 32, output operand width; must be >= IMM_WIDTH+2.
- IMM_WIDTH, 16, immediate field width; must be >= 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  Data/ExtMode valid this cycle.
- in_ready  output  1  block can accept input this cycle.
- Data  input  IMM_WIDTH  raw immediate.
- ExtMode  input  2  extension mode:
  - 00 sign.
  - 01 zero.
  - 10 load-upper.
  - 11 branch-offset.
- out_valid  output  1  ExtImm holds a valid result.
- out_ready  input  1  consumer accepts ExtImm this cycle.
- ExtImm  output  WORD_LENGTH  extended immediate.

## Operation
- Extension is computed combinationally from Data/ExtMode at the input. Only extended words are stored.
  - 00: Data[IMM_WIDTH-1] replicated into bits WORD_LENGTH-1..IMM_WIDTH.
  - 01: upper WORD_LENGTH-IMM_WIDTH bits zero.
  - 10: Data placed in bits WORD_LENGTH-1..WORD_LENGTH-IMM_WIDTH; lower bits zero.
  - 11: sign-extended value shifted left by 2; bits 1..0 zero; the two MSBs shifted out are discarded.
- Storage:
  - Output register OUT (drives ExtImm, out_valid).
  - Skid register SKID with flag skid_valid.
- in_ready = ~skid_valid, taken from a flop only; no combinational path from out_ready.
- Accept = in_valid & in_ready. Output slot free = ~out_valid | out_ready.
- Per rising edge:
  - Slot free, skid_valid=1: OUT <= SKID; skid_valid <= 0. No accept is possible, because in_ready=0.
  - Slot free, skid_valid=0, accept: OUT <= ext(input); out_valid <= 1.
  - Slot free, skid_valid=0, no accept: out_valid <= 0; ExtImm holds its last value.
  - Slot busy (out_valid=1, out_ready=0), accept: SKID <= ext(input); skid_valid <= 1.
  - Slot busy, no accept: everything holds.
- State encoding (out_valid, skid_valid):
  - EMPTY (0,0), ONE (1,0), FULL (1,1).
  - (0,1) is illegal and never reachable.
- Ordering: strictly FIFO. SKID always drains before any newer input reaches OUT.
- While out_valid=1 & out_ready=0, ExtImm and out_valid stay stable.
- Reset (asynchronous, any time):
  - out_valid=0, skid_valid=0, ExtImm=0, SKID=0, in_ready=1.
  - In-flight entries are discarded, including reset asserted mid-stall.
  - First accept is possible on the first rising edge after reset deasserts.

## Timing
- Latency: 1 cycle. An input accepted at edge N is visible on ExtImm after edge N.
- Throughput: 1 per cycle while out_ready=1.
- Backpressure response: the first stalled cycle absorbs one word into SKID. in_ready falls in the next cycle and rises again the cycle after SKID drains.
- Simultaneous accept and output consume in ONE: OUT is replaced and out_valid stays 1, with no bubble.
- Maximum occupancy is 2 words. No word is dropped or duplicated under any in_valid/out_ready pattern.

## Test plan
- Modes (32/16), out_ready=1, one input per cycle:
  - Data 0x8001, mode 00 -> 0xFFFF8001.
  - Data 0x8001, mode 01 -> 0x00008001.
  - Data 0x1234, mode 10 -> 0x12340000.
  - Data 0xFFFF, mode 11 -> 0xFFFFFFFC.
  - Data 0x7FFF, mode 11 -> 0x0001FFFC.
  - Each result appears one cycle after accept.
- Streaming: 8 back-to-back inputs with out_ready=1 -> 8 consecutive out_valid cycles, in order, no bubbles, in_ready constantly 1.
- Backpressure: send A, B, C with out_ready=0 from the cycle after A is accepted.
  - A is held on ExtImm and B is captured in SKID.
  - in_ready=0 and C is held off.
  - Raise out_ready: outputs A, B, C in order, with no loss or duplication.
- Random stress: random in_valid/out_ready for 10k cycles against a scoreboard -> exact order and values, out_valid/ExtImm stable while stalled, state (0,1) never seen.
- Reset mid-operation: assert reset in FULL state, asynchronously between edges -> out_valid=0, ExtImm=0 and in_ready=1 immediately. Neither stored word ever appears afterwards.
- Parameter sweep: WORD_LENGTH=64, IMM_WIDTH=12, Data 0x800, mode 00 -> 0xFFFFFFFFFFFFF800.
